// File: rtl/hdv_engine_stream_sched_if.sv
// Stream/handshake bundle between the AXIS sample sources, the scheduler and the hdv_engine kernel.
// The master modport is the scheduler side; the slave modport is the sources-plus-engine side.
interface hdv_engine_stream_sched_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32
);
  logic [N_REQ*DATA_W-1:0] s_tdata;
  logic [N_REQ-1:0]        s_tvalid;
  logic [N_REQ-1:0]        s_tlast;
  logic [N_REQ-1:0]        s_tready;
  logic [DATA_W-1:0]       m_tdata;
  logic                    m_tvalid;
  logic                    m_tlast;
  logic                    m_tready;
  logic                    eng_ap_start;
  logic                    eng_ap_ready;
  logic                    eng_ap_done;
  logic                    eng_ap_idle;

  modport master (
    input  s_tdata, s_tvalid, s_tlast, m_tready, eng_ap_ready, eng_ap_done, eng_ap_idle,
    output s_tready, m_tdata, m_tvalid, m_tlast, eng_ap_start
  );

  modport slave (
    output s_tdata, s_tvalid, s_tlast, m_tready, eng_ap_ready, eng_ap_done, eng_ap_idle,
    input  s_tready, m_tdata, m_tvalid, m_tlast, eng_ap_start
  );
endinterface

// File: rtl/hdv_engine_stream_sched.sv
// Packet-level round-robin scheduler sharing one hdv_engine between N_REQ AXIS sources.
// Define HDV_SCHED_WDOG_EN to build the no-progress watchdog that drives stall_err.
module hdv_engine_stream_sched #(
  parameter int  N_REQ       = 4,
  parameter int  DATA_W      = 32,
  parameter int  WDOG_CYCLES = 1024,
  localparam int ID_W        = $clog2(N_REQ)
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  hdv_engine_stream_sched_if.master       bus,
  output logic [ID_W-1:0]                 grant_id,
  output logic                            busy,
  output logic [31:0]                     pkt_cnt,
  output logic                            stall_err
);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              start_q, start_d;
  logic [31:0]       pkt_cnt_q, pkt_cnt_d;

  logic              arb_hit;
  logic [ID_W-1:0]   arb_id;
  logic [DATA_W-1:0] sel_data;
  logic              sel_valid;
  logic              sel_last;
  logic              stream_act;
  logic              beat;
  logic              done_evt;

  // Walk downwards so the lane closest after rr_ptr is the last (winning) assignment.
  always_comb begin
    int cand;
    arb_hit = 1'b0;
    arb_id  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = (int'(rr_ptr_q) + k) % N_REQ;
      if (bus.s_tvalid[cand]) begin
        arb_hit = 1'b1;
        arb_id  = ID_W'(cand);
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        sel_data  = bus.s_tdata[i*DATA_W +: DATA_W];
        sel_valid = bus.s_tvalid[i];
        sel_last  = bus.s_tlast[i];
      end
    end
  end

  // Gating with ap_rst_n stops forwarding in the very cycle a mid-packet reset is asserted.
  assign stream_act = (state_q == STREAM) && ap_rst_n;
  assign beat       = stream_act && sel_valid && bus.m_tready;
  assign done_evt   = bus.eng_ap_done && (state_q != IDLE);

  always_comb begin
    bus.m_tdata  = stream_act ? sel_data : '0;
    bus.m_tvalid = stream_act && sel_valid;
    bus.m_tlast  = stream_act && sel_last;
    bus.s_tready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.s_tready[i] = stream_act && bus.m_tready && (grant_id_q == ID_W'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    pkt_cnt_d  = pkt_cnt_q;
    start_d    = start_q && !bus.eng_ap_ready;
    unique case (state_q)
      IDLE: begin
        if (arb_hit && bus.eng_ap_idle) begin
          grant_id_d = arb_id;
          start_d    = 1'b1;
          state_d    = STREAM;
        end
      end
      STREAM: begin
        if (!done_evt && beat && sel_last) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
      end
      default: state_d = IDLE;
    endcase
    // An early ap_done in STREAM completes the invocation exactly like one in WAIT_DONE.
    if (done_evt) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
      rr_ptr_d  = grant_id_q;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= ID_W'(N_REQ - 1);
      start_q    <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      start_q    <= start_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign grant_id         = grant_id_q;
  assign busy             = (state_q != IDLE);
  assign pkt_cnt          = pkt_cnt_q;
  assign bus.eng_ap_start = start_q;

`ifdef HDV_SCHED_WDOG_EN
  logic [31:0] wdog_q, wdog_d;
  logic        stall_q, stall_d;

  // Counter parks at WDOG_CYCLES once the flag is raised; progress or completion rearms it.
  always_comb begin
    wdog_d  = wdog_q;
    stall_d = stall_q;
    if (state_q == IDLE || beat || done_evt) begin
      wdog_d = '0;
    end else if (wdog_q == 32'(WDOG_CYCLES)) begin
      stall_d = 1'b1;
    end else begin
      wdog_d = wdog_q + 32'd1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      wdog_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      stall_q <= stall_d;
    end
  end

  assign stall_err = stall_q;
`else
  logic wdog_unused;
  assign wdog_unused = |32'(WDOG_CYCLES);
  assign stall_err   = 1'b0;
`endif

endmodule

// File: tb/tb_hdv_engine_stream_sched.sv
// Scoreboard bench for hdv_engine_stream_sched: per-lane expected beats plus a cycle model of
// grant/start/count/watchdog behaviour, with a small responder standing in for the engine.
module tb_hdv_engine_stream_sched;
  localparam int N_REQ  = 4;
  localparam int DATA_W = 32;
  localparam int WDOG   = 16;
  localparam int ID_W   = 2;
`ifdef HDV_SCHED_WDOG_EN
  localparam logic EXP_STALL = 1'b1;
`else
  localparam logic EXP_STALL = 1'b0;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic            ap_clk = 1'b0;
  logic            ap_rst_n = 1'b0;
  logic [ID_W-1:0] grant_id;
  logic            busy;
  logic [31:0]     pkt_cnt;
  logic            stall_err;

  hdv_engine_stream_sched_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  hdv_engine_stream_sched #(.N_REQ(N_REQ), .DATA_W(DATA_W), .WDOG_CYCLES(WDOG)) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .bus       (bus),
    .grant_id  (grant_id),
    .busy      (busy),
    .pkt_cnt   (pkt_cnt),
    .stall_err (stall_err)
  );

  always #5 ap_clk = ~ap_clk;

  beat_t src_q[N_REQ][$];
  beat_t exp_q[N_REQ][$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    gap_lane = -1;
  int    gap_at = 0;
  int    gap_len = 0;
  int    lane_out[N_REQ];
  int    dut_glog[$];
  bit    force_done = 1'b0;

  bit              model_valid = 1'b0;
  int              m_state = 0;
  logic [ID_W-1:0] m_grant = '0;
  logic [ID_W-1:0] m_rr = ID_W'(N_REQ - 1);
  bit              m_start = 1'b0;
  logic [31:0]     m_cnt = '0;
  int              m_wd = 0;
  bit              m_stall = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int lane, input int nbeats, input logic [DATA_W-1:0] base);
    beat_t b;
    for (int k = 0; k < nbeats; k++) begin
      b.data = base + DATA_W'(k);
      b.last = (k == nbeats - 1);
      src_q[lane].push_back(b);
      exp_q[lane].push_back(b);
    end
  endtask

  task automatic waitIdle(input int max_cycles);
    int  n = 0;
    bit  empty;
    do begin
      @(negedge ap_clk);
      n++;
      empty = 1'b1;
      for (int i = 0; i < N_REQ; i++) if (src_q[i].size() != 0) empty = 1'b0;
    end while (!(empty && m_state == 0 && bus.eng_ap_idle) && n < max_cycles);
    if (n >= max_cycles) checkOutput("drain_timeout", 1, 0);
    @(negedge ap_clk);
  endtask

  task automatic waitGrant(input int max_cycles);
    int n = 0;
    while (m_state == 0 && n < max_cycles) begin
      @(negedge ap_clk);
      n++;
    end
    if (n >= max_cycles) checkOutput("grant_timeout", 1, 0);
  endtask

  task automatic pulseReset();
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b0;
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
  endtask

  // Sources: present the head of each lane queue, pop on handshake, optional mid-packet gap.
  initial begin
    bit fire[N_REQ];
    int lane_beats[N_REQ];
    int gap_cnt[N_REQ];
    for (int i = 0; i < N_REQ; i++) begin
      lane_beats[i] = 0;
      gap_cnt[i] = 0;
    end
    bus.s_tvalid = '0;
    bus.s_tlast  = '0;
    bus.s_tdata  = '0;
    forever begin
      @(negedge ap_clk);
      for (int i = 0; i < N_REQ; i++) fire[i] = ap_rst_n && bus.s_tvalid[i] && bus.s_tready[i];
      @(posedge ap_clk); #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (fire[i] && src_q[i].size() > 0) begin
          void'(src_q[i].pop_front());
          lane_beats[i]++;
          if (i == gap_lane && lane_beats[i] == gap_at) gap_cnt[i] = gap_len;
        end
        if (gap_cnt[i] > 0) begin
          bus.s_tvalid[i] = 1'b0;
          gap_cnt[i]--;
        end else if (src_q[i].size() > 0) begin
          bus.s_tvalid[i] = 1'b1;
          bus.s_tdata[i*DATA_W +: DATA_W] = src_q[i][0].data;
          bus.s_tlast[i] = src_q[i][0].last;
        end else begin
          bus.s_tvalid[i] = 1'b0;
          bus.s_tlast[i] = 1'b0;
        end
      end
    end
  end

  // Engine responder: one ap_ready per start, ap_done two cycles after the last beat or on demand.
  initial begin
    bit st, lastb, rs, rdy_given;
    int done_cnt;
    rdy_given = 1'b0;
    done_cnt = 0;
    bus.eng_ap_ready = 1'b0;
    bus.eng_ap_done  = 1'b0;
    bus.eng_ap_idle  = 1'b1;
    forever begin
      @(negedge ap_clk);
      st    = bus.eng_ap_start;
      lastb = ap_rst_n && bus.m_tvalid && bus.m_tready && bus.m_tlast;
      rs    = ap_rst_n;
      @(posedge ap_clk); #1;
      bus.eng_ap_ready = 1'b0;
      bus.eng_ap_done  = 1'b0;
      if (!rs) begin
        bus.eng_ap_idle = 1'b1;
        rdy_given = 1'b0;
        done_cnt = 0;
      end else begin
        if (st && !rdy_given) begin
          bus.eng_ap_ready = 1'b1;
          bus.eng_ap_idle  = 1'b0;
          rdy_given = 1'b1;
        end
        if (force_done) begin
          force_done = 1'b0;
          done_cnt = 0;
          bus.eng_ap_done = 1'b1;
          bus.eng_ap_idle = 1'b1;
          rdy_given = 1'b0;
        end else if (done_cnt > 0) begin
          done_cnt--;
          if (done_cnt == 0) begin
            bus.eng_ap_done = 1'b1;
            bus.eng_ap_idle = 1'b1;
            rdy_given = 1'b0;
          end
        end
        if (lastb) done_cnt = 2;
      end
    end
  end

  // Monitor: compare DUT against the reference model, then advance the model on pre-edge inputs.
  initial begin
    beat_t           e;
    bit              beat, done, found, granted_prev;
    int              cand;
    logic [N_REQ-1:0] exp_rdy;
    granted_prev = 1'b0;
    for (int i = 0; i < N_REQ; i++) lane_out[i] = 0;
    forever begin
      @(negedge ap_clk);
      if (model_valid) begin
        if (granted_prev) dut_glog.push_back(int'(grant_id));
        checkOutput("busy", 64'(busy), 64'(m_state != 0));
        checkOutput("grant_id", 64'(grant_id), 64'(m_grant));
        checkOutput("pkt_cnt", 64'(pkt_cnt), 64'(m_cnt));
        checkOutput("ap_start", 64'(bus.eng_ap_start), 64'(m_start));
        checkOutput("stall_err", 64'(stall_err), 64'(m_stall));
        checkOutput("m_tvalid", 64'(bus.m_tvalid),
                    64'(ap_rst_n && m_state == 1 && bus.s_tvalid[m_grant]));
        exp_rdy = '0;
        exp_rdy[m_grant] = ap_rst_n && m_state == 1 && bus.m_tready;
        checkOutput("s_tready", 64'(bus.s_tready), 64'(exp_rdy));
      end
      granted_prev = 1'b0;
      if (!ap_rst_n) begin
        m_state = 0; m_grant = '0; m_rr = ID_W'(N_REQ - 1); m_start = 1'b0;
        m_cnt = '0; m_wd = 0; m_stall = 1'b0;
        model_valid = 1'b1;
      end else if (model_valid) begin
        beat = (m_state == 1) && bus.s_tvalid[m_grant] && bus.m_tready;
        done = bus.eng_ap_done && (m_state != 0);
        e.last = 1'b0;
        if (beat) begin
          if (exp_q[m_grant].size() == 0) begin
            checkOutput("unexp_beat", 1, 0);
          end else begin
            e = exp_q[m_grant].pop_front();
            checkOutput("m_tdata", 64'(bus.m_tdata), 64'(e.data));
            checkOutput("m_tlast", 64'(bus.m_tlast), 64'(e.last));
            lane_out[m_grant]++;
          end
        end
`ifdef HDV_SCHED_WDOG_EN
        if (m_state == 0 || beat || done) m_wd = 0;
        else if (m_wd == WDOG) m_stall = 1'b1;
        else m_wd++;
`endif
        if (m_start && bus.eng_ap_ready) m_start = 1'b0;
        if (m_state == 0) begin
          found = 1'b0;
          for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(m_rr) + k) % N_REQ;
            if (!found && bus.s_tvalid[cand]) begin
              found = 1'b1;
              m_grant = ID_W'(cand);
            end
          end
          if (found && bus.eng_ap_idle) begin
            m_state = 1;
            m_start = 1'b1;
            granted_prev = 1'b1;
          end
        end else if (done) begin
          m_cnt = m_cnt + 32'd1;
          m_rr = m_grant;
          m_state = 0;
        end else if (m_state == 1 && beat && e.last) begin
          m_state = 2;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int base;
    bus.m_tready = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    @(negedge ap_clk);
    checkOutput("rst_busy", 64'(busy), 0);
    checkOutput("rst_start", 64'(bus.eng_ap_start), 0);
    checkOutput("rst_pkt_cnt", 64'(pkt_cnt), 0);
    checkOutput("rst_grant", 64'(grant_id), 0);
    checkOutput("rst_m_tvalid", 64'(bus.m_tvalid), 0);
    checkOutput("rst_m_tdata", 64'(bus.m_tdata), 0);
    checkOutput("rst_stall", 64'(stall_err), 0);

    $display("[TB] single 4-beat packet on lane 0");
    applyStimulus(0, 4, 32'h0000_0100);
    waitIdle(200);
    checkOutput("t1_pkt_cnt", 64'(pkt_cnt), 1);
    checkOutput("t1_grant", 64'(grant_id), 0);
    checkOutput("t1_busy", 64'(busy), 0);
    checkOutput("t1_beats", 64'(lane_out[0]), 4);

    $display("[TB] all lanes requesting, 8 invocations");
    pulseReset();
    dut_glog.delete();
    for (int r = 0; r < 2; r++)
      for (int l = 0; l < N_REQ; l++) applyStimulus(l, 3, 32'(l * 256 + r * 16));
    waitIdle(600);
    checkOutput("t2_glog_size", 64'(dut_glog.size()), 8);
    for (int k = 0; k < 8 && k < dut_glog.size(); k++)
      checkOutput($sformatf("t2_order%0d", k), 64'(dut_glog[k]), 64'(k % N_REQ));
    checkOutput("t2_pkt_cnt", 64'(pkt_cnt), 8);

    $display("[TB] lane 2 valid gap with lane 1 waiting");
    dut_glog.delete();
    gap_lane = 2; gap_at = 2; gap_len = 5;
    applyStimulus(2, 6, 32'h0000_0200);
    waitGrant(50);
    applyStimulus(1, 3, 32'h0000_0110);
    waitIdle(300);
    gap_lane = -1;
    checkOutput("t3_glog_size", 64'(dut_glog.size()), 2);
    if (dut_glog.size() >= 2) begin
      checkOutput("t3_first", 64'(dut_glog[0]), 2);
      checkOutput("t3_second", 64'(dut_glog[1]), 1);
    end

    $display("[TB] m_tready toggling on 6-beat packet");
    base = lane_out[2];
    applyStimulus(2, 6, 32'h0000_0300);
    repeat (30) begin
      @(posedge ap_clk); #1;
      bus.m_tready = ~bus.m_tready;
    end
    bus.m_tready = 1'b1;
    waitIdle(200);
    checkOutput("t4_beats", 64'(lane_out[2] - base), 6);

    $display("[TB] reset mid-packet");
    base = lane_out[1];
    applyStimulus(1, 6, 32'h0000_0400);
    waitGrant(50);
    applyStimulus(3, 2, 32'h0000_0500);
    for (int n = 0; n < 50 && lane_out[1] < base + 2; n++) @(negedge ap_clk);
    pulseReset();
    @(negedge ap_clk);
    dut_glog.delete();
    checkOutput("t5_busy", 64'(busy), 0);
    checkOutput("t5_start", 64'(bus.eng_ap_start), 0);
    checkOutput("t5_pkt_cnt", 64'(pkt_cnt), 0);
    checkOutput("t5_grant", 64'(grant_id), 0);
    checkOutput("t5_m_tvalid", 64'(bus.m_tvalid), 0);
    checkOutput("t5_s_tready", 64'(bus.s_tready), 0);
    waitIdle(300);
    checkOutput("t5_glog_size", 64'(dut_glog.size()), 2);
    if (dut_glog.size() >= 2) begin
      checkOutput("t5_regrant_first", 64'(dut_glog[0]), 1);
      checkOutput("t5_regrant_second", 64'(dut_glog[1]), 3);
    end
    checkOutput("t5_beats", 64'(lane_out[1] - base), 6);
    checkOutput("t5_pkt_cnt_after", 64'(pkt_cnt), 2);

    $display("[TB] stalled stream and watchdog");
    base = lane_out[0];
    dut_glog.delete();
    @(posedge ap_clk); #1;
    bus.m_tready = 1'b0;
    applyStimulus(0, 4, 32'h0000_0600);
    repeat (30) @(negedge ap_clk);
    checkOutput("t6_busy", 64'(busy), 1);
    checkOutput("t6_stall", 64'(stall_err), 64'(EXP_STALL));
    @(posedge ap_clk); #1;
    force_done = 1'b1;
    bus.m_tready = 1'b1;
    waitIdle(200);
    checkOutput("t6_stall_after", 64'(stall_err), 64'(EXP_STALL));
    checkOutput("t6_pkt_cnt", 64'(pkt_cnt), 4);
    checkOutput("t6_beats", 64'(lane_out[0] - base), 4);
    checkOutput("t6_glog_size", 64'(dut_glog.size()), 2);

    for (int i = 0; i < N_REQ; i++)
      checkOutput($sformatf("exp_left%0d", i), 64'(exp_q[i].size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
